cpu_dbg_port: RTL
=================

CPU_DBG_PORT -- requirements
Module: cpu_dbg_port

Interface
REQ-001 The block SHALL have parameter IO_BASE, default 16'hFF00, giving the base of the 256-byte IO window.
REQ-002 The block SHALL have parameter IO_RD_LAT, default 1, giving the cycles from io_rd to valid io_din (legal range 1-7).
REQ-003 The block SHALL have parameter DM_LAT, default 1, giving the cycles from dm_dbg_addr to valid dm_dbg_data (legal range 1-3).
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  system clock; one clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  one-cycle CPU memory-access request.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  32  byte address; valid with cpu_req.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle pulse; address outside the IO window.
- io_busy  out  1  high while a transaction is in flight.
- io_addr  out  16  IO bus address.
- io_dout  out  32  IO write data.
- io_we  out  1  IO write strobe.
- io_rd  out  1  IO read strobe.
- io_din  in  32  IO read data.
- chk_addr  in  16  debug inspect address.
- chk_data  out  32  debug inspect data.
- current_pc  in  32  CPU program counter.
- cpu_halt  in  1  CPU stopped by the debug unit.
- rf_dbg_addr  out  5  register-file debug read address; combinational return.
- rf_dbg_data  in  32  register-file debug read data.
- dm_dbg_addr  out  12  data-memory debug word address.
- dm_dbg_data  in  32  data-memory debug read data; DM_LAT cycles after address.

Function
REQ-005 The IO FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-006 In IDLE, cpu_req with cpu_addr[31:8] == {16'h0, IO_BASE[15:8]} SHALL latch we/addr[15:0]/wdata and go to ISSUE next cycle.
REQ-007 In IDLE, cpu_req to any other address SHALL pulse cpu_ready and cpu_err together on the next cycle with cpu_rdata = 0 and SHALL drive no IO strobe.
REQ-008 ISSUE SHALL last exactly one cycle:
- io_addr and io_dout are driven from the latched values.
- Exactly one of io_we or io_rd is high.
- A write then goes to DONE; a read goes to WAIT.
REQ-009 WAIT SHALL count IO_RD_LAT cycles from the ISSUE cycle, capture io_din on the final count, then go to DONE.
REQ-010 DONE SHALL last one cycle: cpu_ready = 1, cpu_rdata = captured data (0 for writes), then return to IDLE.
REQ-011 Read latency SHALL be cpu_req -> cpu_ready = IO_RD_LAT+2 cycles; write latency SHALL be 2 cycles.
REQ-012 io_busy SHALL be high in ISSUE, WAIT and DONE.
REQ-013 cpu_req while io_busy is high SHALL be ignored, with no queuing.
REQ-014 io_addr SHALL hold its last value outside ISSUE; io_we and io_rd SHALL be 0 outside ISSUE.
REQ-015 A 32-bit io_count SHALL increment on every DONE and wrap from FFFFFFFF to 0; error completions SHALL NOT count.
REQ-016 The debug FSM SHALL loop SEL -> WAIT -> UPD continuously, independent of the IO FSM.
REQ-017 SEL SHALL latch chk_addr into an internal address register.
REQ-018 chk_addr[15:12] SHALL select the inspect space:
- 0x0: register file at chk_addr[4:0]; register 0 reads 0.
- 0x1: data memory at word chk_addr[11:0].
- 0xF: status, selected by chk_addr[1:0]: 0 current_pc, 1 {16'h0, last io_addr}, 2 io_count, 3 {31'h0, cpu_halt}.
- Any other value: 32'h0.
REQ-019 WAIT SHALL last DM_LAT cycles for space 0x1 and 1 cycle for all other spaces.
REQ-020 UPD SHALL load chk_data in one cycle.
REQ-021 A chk_addr change SHALL be reflected on chk_data within DM_LAT+4 cycles.
REQ-022 chk_data SHALL hold its last value between updates, with no glitching.
REQ-023 rf_dbg_addr and dm_dbg_addr SHALL be driven from the latched debug address only.
REQ-024 The debug side SHALL never drive io_* signals nor affect cpu_ready.

Reset
REQ-025 When rst is sampled high, the following SHALL hold from the next edge:
- Both FSMs are in IDLE/SEL.
- cpu_ready, cpu_err, io_we, io_rd, io_busy = 0.
- io_addr, io_dout, cpu_rdata, chk_data, io_count, dm_dbg_addr = 0; rf_dbg_addr = 0.
REQ-026 rst SHALL override every other input in the same cycle.
REQ-027 rst during ISSUE, WAIT or DONE SHALL abort the transaction with no cpu_ready pulse; a strobe already driven in ISSUE is not retracted.

Verification
REQ-028 IO read: cpu_req, we=0, addr=0x0000FF10, io_din=0x12345678, IO_RD_LAT=1 -> io_rd high exactly 1 cycle with io_addr=FF10; cpu_ready on cycle 3 with cpu_rdata=0x12345678; io_count=1.
REQ-029 IO write: we=1, addr=0x0000FF00, wdata=0xA5 -> io_we 1 cycle, io_dout=0xA5; cpu_ready on cycle 2 with cpu_rdata=0.
REQ-030 Out-of-window and busy requests:
- addr=0x00001000 -> cpu_ready and cpu_err together next cycle; no strobe; io_count unchanged.
- A second cpu_req during WAIT -> ignored, exactly one cpu_ready.
REQ-031 Debug inspect:
- chk_addr=0x1004, dm_dbg_data=0xCAFEF00D -> dm_dbg_addr=0x004 and chk_data=0xCAFEF00D within DM_LAT+4 cycles.
- chk_addr=0xF000 -> chk_data=current_pc.
- chk_addr=0x0000 -> chk_data=0.
REQ-032 Reset mid-read: rst during WAIT -> no cpu_ready; all outputs are at reset values on the next cycle; a new request then completes normally.
REQ-033 Wrap: io_count forced to FFFFFFFF, one write -> chk_addr=0xF002 reads 0.

Source files
------------

// File: rtl/cpu_dbg_port_if.sv
// Bus bundle between the CPU/IO/debug side and cpu_dbg_port.
// slave is the port view, master is the environment view.
interface cpu_dbg_port_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        io_busy;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;
    logic [15:0] chk_addr;
    logic [31:0] chk_data;
    logic [31:0] current_pc;
    logic        cpu_halt;
    logic [4:0]  rf_dbg_addr;
    logic [31:0] rf_dbg_data;
    logic [11:0] dm_dbg_addr;
    logic [31:0] dm_dbg_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, io_din, chk_addr,
               current_pc, cpu_halt, rf_dbg_data, dm_dbg_data,
        output cpu_rdata, cpu_ready, cpu_err, io_busy, io_addr, io_dout,
               io_we, io_rd, chk_data, rf_dbg_addr, dm_dbg_addr
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, io_din, chk_addr,
               current_pc, cpu_halt, rf_dbg_data, dm_dbg_data,
        input  cpu_rdata, cpu_ready, cpu_err, io_busy, io_addr, io_dout,
               io_we, io_rd, chk_data, rf_dbg_addr, dm_dbg_addr
    );
endinterface

// File: rtl/cpu_dbg_port.sv
// CPU-to-IO bridge for a 256-byte IO window plus a free-running debug
// inspector that samples register file, data memory or bridge status.
module cpu_dbg_port #(
    parameter logic [15:0]  IO_BASE   = 16'hFF00,
    parameter int unsigned  IO_RD_LAT = 1,
    parameter int unsigned  DM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_dbg_port_if.slave         bus_io
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IO_AW  = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DM_W   = 2;

    typedef enum logic [1:0] {IO_IDLE, IO_ISSUE, IO_WAIT, IO_DONE} io_state_e;
    typedef enum logic [1:0] {DBG_SEL, DBG_WAIT, DBG_UPD} dbg_state_e;

    io_state_e           io_state_q;
    logic                we_q;
    logic [IO_AW-1:0]    io_addr_q;
    logic [DATA_W-1:0]   io_dout_q;
    logic                io_we_q;
    logic                io_rd_q;
    logic                io_busy_q;
    logic                cpu_ready_q;
    logic                cpu_err_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [DATA_W-1:0]   io_count_q;
    logic [DATA_W-1:0]   io_count_d;
    logic                in_window_c;

    dbg_state_e          dbg_state_q;
    logic [IO_AW-1:0]    dbg_addr_q;
    logic [DM_W-1:0]     dbg_wait_q;
    logic [DATA_W-1:0]   chk_data_q;
    logic [DATA_W-1:0]   chk_data_d;

    assign in_window_c = (bus_io.cpu_addr[31:8] == {16'h0, IO_BASE[15:8]});
    assign io_count_d  = io_count_q + DATA_W'(1);

    // IO bridge FSM; strobes and completion flags are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            io_state_q  <= IO_IDLE;
            we_q        <= 1'b0;
            io_addr_q   <= '0;
            io_dout_q   <= '0;
            io_we_q     <= 1'b0;
            io_rd_q     <= 1'b0;
            io_busy_q   <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            wait_cnt_q  <= '0;
            io_count_q  <= '0;
        end else begin
            io_we_q     <= 1'b0;
            io_rd_q     <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            case (io_state_q)
                IO_IDLE: begin
                    if (bus_io.cpu_req) begin
                        if (in_window_c) begin
                            we_q       <= bus_io.cpu_we;
                            io_addr_q  <= bus_io.cpu_addr[15:0];
                            io_dout_q  <= bus_io.cpu_wdata;
                            io_we_q    <= bus_io.cpu_we;
                            io_rd_q    <= ~bus_io.cpu_we;
                            io_busy_q  <= 1'b1;
                            io_state_q <= IO_ISSUE;
                        end else begin
                            cpu_ready_q <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
                        end
                    end
                end
                IO_ISSUE: begin
                    if (we_q) begin
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= '0;
                        io_state_q  <= IO_DONE;
                    end else begin
                        wait_cnt_q <= CNT_W'(1);
                        io_state_q <= IO_WAIT;
                    end
                end
                IO_WAIT: begin
                    // io_din is valid IO_RD_LAT cycles after the ISSUE cycle
                    if (wait_cnt_q == CNT_W'(IO_RD_LAT)) begin
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= bus_io.io_din;
                        io_state_q  <= IO_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                IO_DONE: begin
                    io_count_q <= io_count_d;
                    io_busy_q  <= 1'b0;
                    io_state_q <= IO_IDLE;
                end
                default: io_state_q <= IO_IDLE;
            endcase
        end
    end

    // Inspect mux, sampled only in UPD
    always_comb begin
        chk_data_d = '0;
        case (dbg_addr_q[15:12])
            4'h0: if (dbg_addr_q[4:0] != 5'd0) chk_data_d = bus_io.rf_dbg_data;
            4'h1: chk_data_d = bus_io.dm_dbg_data;
            4'hF: begin
                case (dbg_addr_q[1:0])
                    2'd0:    chk_data_d = bus_io.current_pc;
                    2'd1:    chk_data_d = {16'h0, io_addr_q};
                    2'd2:    chk_data_d = io_count_q;
                    default: chk_data_d = {31'h0, bus_io.cpu_halt};
                endcase
            end
            default: chk_data_d = '0;
        endcase
    end

    // Debug loop; a chk_addr change seen in WAIT restarts at SEL to bound latency
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_state_q <= DBG_SEL;
            dbg_addr_q  <= '0;
            dbg_wait_q  <= '0;
            chk_data_q  <= '0;
        end else begin
            case (dbg_state_q)
                DBG_SEL: begin
                    dbg_addr_q  <= bus_io.chk_addr;
                    dbg_wait_q  <= DM_W'(1);
                    dbg_state_q <= DBG_WAIT;
                end
                DBG_WAIT: begin
                    if (bus_io.chk_addr != dbg_addr_q) begin
                        dbg_state_q <= DBG_SEL;
                    end else if (dbg_addr_q[15:12] != 4'h1 ||
                                 dbg_wait_q == DM_W'(DM_LAT)) begin
                        dbg_state_q <= DBG_UPD;
                    end else begin
                        dbg_wait_q <= dbg_wait_q + DM_W'(1);
                    end
                end
                DBG_UPD: begin
                    chk_data_q  <= chk_data_d;
                    dbg_state_q <= DBG_SEL;
                end
                default: dbg_state_q <= DBG_SEL;
            endcase
        end
    end

    assign bus_io.cpu_rdata   = cpu_rdata_q;
    assign bus_io.cpu_ready   = cpu_ready_q;
    assign bus_io.cpu_err     = cpu_err_q;
    assign bus_io.io_busy     = io_busy_q;
    assign bus_io.io_addr     = io_addr_q;
    assign bus_io.io_dout     = io_dout_q;
    assign bus_io.io_we       = io_we_q;
    assign bus_io.io_rd       = io_rd_q;
    assign bus_io.chk_data    = chk_data_q;
    assign bus_io.rf_dbg_addr = dbg_addr_q[4:0];
    assign bus_io.dm_dbg_addr = dbg_addr_q[11:0];
endmodule
